// File: rtl/usb_keyboard_pkg.sv
// Shared types for the ASCII-to-HID keystroke typer: FSM encoding, modifier
// constants and the character translation function.
package usb_keyboard_pkg;

    localparam logic [7:0] MOD_LSHIFT = 8'h02;
    localparam int         GAP_W      = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_FIRE   = 2'd2,
        ST_GAP    = 2'd3
    } typer_state_e;

    typedef struct packed {
        logic       supported;
        logic [7:0] modifier;
        logic [7:0] usage;
    } hid_key_t;

    function automatic hid_key_t hid_key(input logic shift, input logic [7:0] usage);
        hid_key_t k;
        k.supported = 1'b1;
        k.modifier  = shift ? MOD_LSHIFT : 8'h00;
        k.usage     = usage;
        return k;
    endfunction

    function automatic hid_key_t ascii_to_hid(input logic [7:0] c);
        hid_key_t k;
        k = '0;
        if (c >= 8'h61 && c <= 8'h7A) begin
            k = hid_key(1'b0, c - 8'h5D);
        end else if (c >= 8'h41 && c <= 8'h5A) begin
            k = hid_key(1'b1, c - 8'h3D);
        end else if (c >= 8'h31 && c <= 8'h39) begin
            k = hid_key(1'b0, c - 8'h13);
        end else begin
            case (c)
                8'h30: k = hid_key(1'b0, 8'h27);
                8'h0A: k = hid_key(1'b0, 8'h28);
                8'h08: k = hid_key(1'b0, 8'h2A);
                8'h09: k = hid_key(1'b0, 8'h2B);
                8'h20: k = hid_key(1'b0, 8'h2C);
                8'h2D: k = hid_key(1'b0, 8'h2D);
                8'h3D: k = hid_key(1'b0, 8'h2E);
                8'h5B: k = hid_key(1'b0, 8'h2F);
                8'h5D: k = hid_key(1'b0, 8'h30);
                8'h5C: k = hid_key(1'b0, 8'h31);
                8'h3B: k = hid_key(1'b0, 8'h33);
                8'h27: k = hid_key(1'b0, 8'h34);
                8'h60: k = hid_key(1'b0, 8'h35);
                8'h2C: k = hid_key(1'b0, 8'h36);
                8'h2E: k = hid_key(1'b0, 8'h37);
                8'h2F: k = hid_key(1'b0, 8'h38);
                // shifted digit row
                8'h21: k = hid_key(1'b1, 8'h1E);
                8'h40: k = hid_key(1'b1, 8'h1F);
                8'h23: k = hid_key(1'b1, 8'h20);
                8'h24: k = hid_key(1'b1, 8'h21);
                8'h25: k = hid_key(1'b1, 8'h22);
                8'h5E: k = hid_key(1'b1, 8'h23);
                8'h26: k = hid_key(1'b1, 8'h24);
                8'h2A: k = hid_key(1'b1, 8'h25);
                8'h28: k = hid_key(1'b1, 8'h26);
                8'h29: k = hid_key(1'b1, 8'h27);
                8'h5F: k = hid_key(1'b1, 8'h2D);
                8'h2B: k = hid_key(1'b1, 8'h2E);
                8'h7B: k = hid_key(1'b1, 8'h2F);
                8'h7D: k = hid_key(1'b1, 8'h30);
                8'h7C: k = hid_key(1'b1, 8'h31);
                8'h3A: k = hid_key(1'b1, 8'h33);
                8'h22: k = hid_key(1'b1, 8'h34);
                8'h7E: k = hid_key(1'b1, 8'h35);
                8'h3C: k = hid_key(1'b1, 8'h36);
                8'h3E: k = hid_key(1'b1, 8'h37);
                8'h3F: k = hid_key(1'b1, 8'h38);
                default: k = '0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/usb_keyboard_ascii_typer_if.sv
// Character input and keystroke output bundle of the ASCII typer.
// ascii_*: a byte transfers on every clk edge where ascii_valid && ascii_ready;
// key_value is valid only in the single cycle key_request is high.
interface usb_keyboard_ascii_typer_if;
    logic [7:0]  ascii_data;
    logic        ascii_valid;
    logic        ascii_ready;
    logic [15:0] key_value;
    logic        key_request;

    modport master (
        output ascii_data, ascii_valid,
        input  ascii_ready, key_value, key_request
    );

    modport slave (
        input  ascii_data, ascii_valid,
        output ascii_ready, key_value, key_request
    );
endinterface

// File: rtl/usb_sync_fifo.sv
// Generic synchronous FIFO, 2^AW entries, with full/empty flags.
// Reads are fall-through: rd_data_o always shows the head entry.
module usb_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_wr;
    logic          do_rd;

    // full is judged on the pre-pop count, so a push into a full FIFO is refused
    // even when a pop happens in the same cycle
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/usb_keyboard_ascii_typer.sv
// Queues ASCII characters and issues them as paced single-cycle HID key
// requests, dropping and counting characters with no keyboard mapping.
module usb_keyboard_ascii_typer
    import usb_keyboard_pkg::*;
#(
    parameter int FIFO_AW    = 4,
    parameter int GAP_CYCLES = 15000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         host_ready,
    usb_keyboard_ascii_typer_if.slave    bus,
    output logic                         busy,
    output logic [7:0]                   err_cnt,
    output typer_state_e                 dbg_state_o
);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 2);
    localparam logic [GAP_W-1:0] GAP_EXIT  = GAP_W'(2);
    localparam bit               SHORT_GAP = (GAP_CYCLES <= 3);

    typer_state_e     state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       char_q, char_d;
    logic [15:0]      key_value_q, key_value_d;
    logic [7:0]       err_q, err_d;
    logic             busy_q;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;
    hid_key_t         hid;

    usb_sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.ascii_valid),
        .wr_data_i (bus.ascii_data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign hid = ascii_to_hid(char_q);

    // The gap counter runs down in every state, so after leaving GAP at 2 it
    // reaches 0 exactly as the next FIRE can occur, giving a GAP_CYCLES pitch.
    always_comb begin
        state_d     = state_q;
        gap_d       = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        char_d      = char_q;
        key_value_d = key_value_q;
        err_d       = err_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && host_ready) begin
                    pop     = 1'b1;
                    char_d  = fifo_rd_data;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hid.supported) begin
                    key_value_d = {hid.modifier, hid.usage};
                    state_d     = ST_FIRE;
                end else begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_FIRE: begin
                gap_d   = GAP_LOAD;
                state_d = SHORT_GAP ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_q <= GAP_EXIT) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_q       <= '0;
            char_q      <= '0;
            key_value_q <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            char_q      <= char_d;
            key_value_q <= key_value_d;
            err_q       <= err_d;
            busy_q      <= !fifo_empty || (state_q != ST_IDLE);
        end
    end

    assign bus.ascii_ready = !fifo_full;
    assign bus.key_value   = key_value_q;
    assign bus.key_request = (state_q == ST_FIRE);
    assign busy            = busy_q;
    assign err_cnt         = err_q;
    assign dbg_state_o     = state_q;
endmodule
